dram_ctrl: RTL and testbench
============================

// Module: dram_ctrl
// PURPOSE
//   Arbitrates and sequences access to the dual-port 16x16 dram. Two requesters,
//   A and B, share a single command path into the dram with round-robin fairness.
//   The block also generates periodic refresh cycles, which take priority over
//   requests at the next idle point.
//   Sits between the client logic and the dram. It drives the dram port-A
//   signals and holds port-B signals inactive.
// PARAMETERS
//   AW              4    address width (dram depth = 2**AW)
//   DW              16   data width
//   REFRESH_PERIOD  64   cycles between refresh requests (must be > REFRESH_CYCLES+4)
//   REFRESH_CYCLES  2    cycles refresh_en is held per refresh
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   req_a/req_b  in   1   access request; hold high until matching ack
//   we_a/we_b    in   1   1=write, 0=read; stable while req high
//   addr_a/b     in   AW  address; stable while req high
//   wdata_a/b    in   DW  write data; stable while req high
//   ack_a/ack_b  out  1   one-cycle completion pulse
//   rdata        out  DW  read data; valid in the cycle ack_x is high after a read
//   mem_we       out  1   dram write enable (port A)
//   mem_re       out  1   dram read enable (port A)
//   mem_refresh  out  1   dram refresh_en
//   mem_addr     out  AW  dram address (port A)
//   mem_wdata    out  DW  dram write data (port A)
//   mem_rdata    in   DW  dram data_out_a; registered, valid 1 cycle after mem_re
//   busy         out  1   high in any state other than IDLE
//   ref_overrun  out  1   sticky: refresh came due while one was already pending
// BEHAVIOUR
//   - All outputs are registered. On reset every output is 0.
//     Reset also sets state=IDLE, ref_cnt=REFRESH_PERIOD-1, ref_pending=0, last_grant=B.
//   - Reset mid-operation aborts immediately: mem_* go 0 and no ack is issued.
//   - FSM states: IDLE, REFRESH, ACCESS, RD_WAIT, DONE.
//     IDLE: ref_pending -> REFRESH (ref_pending has priority over requests);
//       else a request -> ACCESS (latch grant, addr, we, wdata);
//       else stay in IDLE.
//     REFRESH: mem_refresh=1 for exactly REFRESH_CYCLES cycles; clears ref_pending; -> IDLE.
//     ACCESS: 1 cycle; mem_we=we or mem_re=~we; mem_addr/mem_wdata driven.
//       Next state: write -> DONE, read -> RD_WAIT.
//     RD_WAIT: 1 cycle; rdata <= mem_rdata at the end of the cycle; -> DONE.
//     DONE: ack of granted port =1 for 1 cycle; -> IDLE.
//   - Latency, counted from the edge at which IDLE samples the request:
//     write ack appears 2 cycles later; read ack appears 3 cycles later.
//     A new access can start no earlier than 1 cycle after ack (the IDLE cycle).
//   - Handshake: req_x is sampled only in IDLE. The requester must drop req_x or
//     present its next request at the edge where ack_x is high. rdata holds its
//     value until the next read completes.
//   - Arbitration: a single requester is granted. When both request, grant goes to
//     the port opposite last_grant. last_grant updates on each grant, so A wins the
//     first tie after reset.
//     Accesses are serialised, so a same-address write/write pair is ordered by
//     grant and the later grant's data is retained.
//   - Refresh timer: ref_cnt decrements every cycle, including during refresh.
//     At 0 it reloads to REFRESH_PERIOD-1 and sets ref_pending.
//     If ref_pending is already 1 at that point, ref_overrun is set; it clears only
//     on reset.
//     A refresh never pre-empts an access already in ACCESS, RD_WAIT or DONE.
//   - mem_we, mem_re and mem_refresh are mutually exclusive in every cycle.
// TESTING
//   1 Reset: hold rst_n=0 for 2 cycles -> all outputs 0, busy=0.
//     Assert rst_n=0 during ACCESS -> mem_we drops asynchronously and no ack follows.
//   2 Write/read: A writes 16'hAAAA to addr 0 -> ack_a 2 cycles after sampling.
//     A then reads addr 0 -> ack_a after 3 cycles with rdata=16'hAAAA.
//   3 Tie: req_a and req_b both write addr 5 (16'h1111 / 16'h2222) -> A is served
//     first, then B. A read of addr 5 returns 16'h2222.
//   4 Fairness: A and B request continuously for 6 grants -> grant order
//     A,B,A,B,A,B; neither is starved.
//   5 Refresh: REFRESH_PERIOD=16. Issue a B write of 16'hBEEF to addr 9 just as
//     ref_cnt hits 0 -> refresh_en high for 2 cycles, then B's write completes.
//     A later read returns 16'hBEEF; ref_overrun=0.
//   6 Exclusivity: a random stream of requests runs for 2000 cycles -> a checker
//     sees no cycle with two of mem_we/mem_re/mem_refresh high, and exactly one ack
//     per accepted request.

Source files
------------

// File: rtl/dram_ctrl.sv
// Two-port round-robin arbiter and sequencer onto dram port A, with periodic refresh.
// Latency: write ack 2 cycles, read ack 3 cycles after IDLE samples the request.
// Backpressure: req is held until its one-cycle ack; pending refresh wins over requests in IDLE.
module dram_ctrl #(
    parameter int AW             = 4,
    parameter int DW             = 16,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic          mem_refresh,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          ref_overrun
);
    localparam int CW  = $clog2(REFRESH_PERIOD);
    localparam int RCW = $clog2(REFRESH_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, REFRESH, ACCESS, RD_WAIT, DONE} state_t;

    state_t         state, state_nxt;
    logic [RCW-1:0] rcnt, rcnt_nxt;
    logic [CW-1:0]  ref_cnt;
    logic           ref_pending;
    logic           last_grant;      // 1 = B; also identifies the port being served
    logic           lat_we;
    logic           take_req;
    logic           clr_pending;
    logic           grant_nxt;
    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;

    assign sel_we    = grant_nxt ? we_b    : we_a;
    assign sel_addr  = grant_nxt ? addr_b  : addr_a;
    assign sel_wdata = grant_nxt ? wdata_b : wdata_a;

    always_comb begin
        state_nxt   = state;
        rcnt_nxt    = rcnt;
        take_req    = 1'b0;
        clr_pending = 1'b0;
        grant_nxt   = last_grant;
        case (state)
            IDLE: begin
                if (ref_pending) begin
                    state_nxt   = REFRESH;
                    clr_pending = 1'b1;
                    rcnt_nxt    = RCW'(REFRESH_CYCLES - 1);
                end else if (req_a || req_b) begin
                    state_nxt = ACCESS;
                    take_req  = 1'b1;
                    grant_nxt = (req_a && req_b) ? ~last_grant : req_b;
                end
            end
            REFRESH: begin
                if (rcnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    rcnt_nxt = rcnt - 1'b1;
                end
            end
            ACCESS:  state_nxt = lat_we ? DONE : RD_WAIT;
            RD_WAIT: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rcnt       <= '0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            if (take_req) begin
                last_grant <= grant_nxt;
                lat_we     <= sel_we;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            mem_refresh <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            busy        <= 1'b0;
            rdata       <= '0;
        end else begin
            mem_we      <= take_req & sel_we;
            mem_re      <= take_req & ~sel_we;
            mem_refresh <= (state_nxt == REFRESH);
            mem_addr    <= take_req ? sel_addr  : '0;
            mem_wdata   <= take_req ? sel_wdata : '0;
            ack_a       <= (state_nxt == DONE) && !last_grant;
            ack_b       <= (state_nxt == DONE) &&  last_grant;
            busy        <= (state_nxt != IDLE);
            if (state == RD_WAIT) begin
                rdata <= mem_rdata;
            end
        end
    end

    // A refresh falling due on the very edge the previous one is taken is not an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt     <= CW'(REFRESH_PERIOD - 1);
            ref_pending <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            if (ref_cnt == '0) begin
                ref_cnt     <= CW'(REFRESH_PERIOD - 1);
                ref_pending <= 1'b1;
                if (ref_pending && !clr_pending) begin
                    ref_overrun <= 1'b1;
                end
            end else begin
                ref_cnt <= ref_cnt - 1'b1;
                if (clr_pending) begin
                    ref_pending <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dram_ctrl.sv
// Directed and randomised bench for dram_ctrl with a registered-read dram model on port A.
module tb_dram_ctrl;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int RP = 16;
    localparam int RC = 2;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          req_a   = 1'b0;
    logic          req_b   = 1'b0;
    logic          we_a    = 1'b0;
    logic          we_b    = 1'b0;
    logic [AW-1:0] addr_a  = '0;
    logic [AW-1:0] addr_b  = '0;
    logic [DW-1:0] wdata_a = '0;
    logic [DW-1:0] wdata_b = '0;
    logic          ack_a, ack_b, mem_we, mem_re, mem_refresh, busy, ref_overrun;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] dram [2**AW];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dram_ctrl #(.AW(AW), .DW(DW), .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .ref_overrun(ref_overrun)
    );

    always @(posedge clk) begin
        if (mem_we) dram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= dram[mem_addr];
    end

    task automatic idle_inputs();
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    endtask

    // Leaves the bench at a negedge with reset released; the next posedge is cycle 1.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input logic port_b, input int limit, output int lat);
        logic found;
        found = 1'b0;
        lat = 0;
        while (!found && lat < limit) begin
            @(negedge clk);
            lat++;
            if ((port_b ? ack_b : ack_a) === 1'b1) found = 1'b1;
        end
        if (!found) lat = -1;
    endtask

    task automatic test_reset();
        logic seen;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({ack_a, ack_b, mem_we, mem_re, mem_refresh, busy, ref_overrun} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {ack_a, ack_b, mem_we, mem_re, mem_refresh, busy, ref_overrun});
        end
        checks++;
        if ({rdata, mem_wdata, mem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata %h wdata %h addr %h expected all 0", rdata, mem_wdata, mem_addr);
        end
        rst_n = 1'b1;
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'd3; wdata_a = 16'h1234;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: mem_we %b expected 1", mem_we);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_async: mem_we,busy %b expected 00", {mem_we, busy});
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack_a === 1'b1 || ack_b === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_ack: ack seen %b expected 0", seen);
        end
    endtask

    task automatic test_write_read();
        int lat;
        do_reset();
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'd0; wdata_a = 16'hAAAA;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_re, mem_addr, mem_wdata, ack_a} !== {1'b1, 1'b0, 4'd0, 16'hAAAA, 1'b0}) begin
            errors++;
            $display("FAIL wr_access: we %b re %b addr %h wdata %h ack %b expected 1 0 0 aaaa 0",
                     mem_we, mem_re, mem_addr, mem_wdata, ack_a);
        end
        @(negedge clk);
        checks++;
        if ({ack_a, ack_b, mem_we} !== 3'b100) begin
            errors++;
            $display("FAIL wr_ack: ack_a,ack_b,mem_we %b expected 100", {ack_a, ack_b, mem_we});
        end
        req_a = 1'b0;
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b0;
        wait_ack(1'b0, 10, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL rd_latency: got %0d expected 3", lat);
        end
        checks++;
        if (rdata !== 16'hAAAA) begin
            errors++;
            $display("FAIL rd_data: got %h expected aaaa", rdata);
        end
        req_a = 1'b0;
    endtask

    task automatic test_tie();
        int lat;
        do_reset();
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'd5; wdata_a = 16'h1111;
        req_b = 1'b1; we_b = 1'b1; addr_b = 4'd5; wdata_b = 16'h2222;
        wait_ack(1'b0, 10, lat);
        checks++;
        if (lat !== 2 || ack_b !== 1'b0) begin
            errors++;
            $display("FAIL tie_first_a: lat %0d ack_b %b expected 2 0", lat, ack_b);
        end
        req_a = 1'b0;
        wait_ack(1'b1, 10, lat);
        checks++;
        if (lat !== 3 || ack_a !== 1'b0) begin
            errors++;
            $display("FAIL tie_then_b: lat %0d ack_a %b expected 3 0", lat, ack_a);
        end
        req_b = 1'b0;
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b0; addr_a = 4'd5;
        wait_ack(1'b0, 10, lat);
        checks++;
        if (lat !== 3 || rdata !== 16'h2222) begin
            errors++;
            $display("FAIL tie_readback: lat %0d rdata %h expected 3 2222", lat, rdata);
        end
        req_a = 1'b0;
    endtask

    task automatic test_fairness();
        int n;
        logic got_a, got_b;
        do_reset();
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'd1; wdata_a = 16'hA000;
        req_b = 1'b1; we_b = 1'b1; addr_b = 4'd2; wdata_b = 16'hB000;
        for (int g = 0; g < 6; g++) begin
            n = 0; got_a = 1'b0; got_b = 1'b0;
            while (!(got_a || got_b) && n < 20) begin
                @(negedge clk);
                n++;
                got_a = (ack_a === 1'b1);
                got_b = (ack_b === 1'b1);
            end
            checks++;
            if ({got_a, got_b} !== ((g % 2 == 1) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL fair_order_%0d: ack_a,ack_b %b%b expected %s", g, got_a, got_b,
                         (g % 2 == 1) ? "01" : "10");
            end
            if (got_a) wdata_a = wdata_a + 16'd1;
            if (got_b) wdata_b = wdata_b + 16'd1;
        end
        idle_inputs();
    endtask

    // Timer reloads and raises ref_pending at cycle RP; B arrives together with the pending refresh.
    task automatic test_refresh();
        int lat;
        do_reset();
        repeat (RP) @(negedge clk);
        req_b = 1'b1; we_b = 1'b1; addr_b = 4'd9; wdata_b = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({mem_refresh, mem_we, mem_re, busy} !== 4'b1001) begin
            errors++;
            $display("FAIL ref_start: refresh,we,re,busy %b expected 1001", {mem_refresh, mem_we, mem_re, busy});
        end
        @(negedge clk);
        checks++;
        if ({mem_refresh, mem_we} !== 2'b10) begin
            errors++;
            $display("FAIL ref_hold: refresh,we %b expected 10", {mem_refresh, mem_we});
        end
        @(negedge clk);
        checks++;
        if ({mem_refresh, mem_we, ack_b} !== 3'b000) begin
            errors++;
            $display("FAIL ref_end: refresh,we,ack_b %b expected 000", {mem_refresh, mem_we, ack_b});
        end
        @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd9, 16'hBEEF}) begin
            errors++;
            $display("FAIL ref_b_access: we %b addr %h wdata %h expected 1 9 beef", mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (ack_b !== 1'b1) begin
            errors++;
            $display("FAIL ref_b_ack: got %b expected 1", ack_b);
        end
        req_b = 1'b0;
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b0; addr_a = 4'd9;
        wait_ack(1'b0, 10, lat);
        checks++;
        if (lat !== 3 || rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL ref_readback: lat %0d rdata %h expected 3 beef", lat, rdata);
        end
        checks++;
        if (ref_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ref_overrun: got %b expected 0", ref_overrun);
        end
        req_a = 1'b0;
    endtask

    task automatic test_random();
        logic          r  [2];
        logic          w  [2];
        logic [AW-1:0] a  [2];
        logic [DW-1:0] d  [2];
        logic          ak [2];
        int            iss [2];
        int            fin [2];
        logic [DW-1:0] shadow [2**AW];
        logic          sh_vld [2**AW];
        do_reset();
        for (int i = 0; i < 2**AW; i++) begin
            sh_vld[i] = 1'b0;
            shadow[i] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            r[p] = 1'b0; w[p] = 1'b0; a[p] = '0; d[p] = '0; iss[p] = 0; fin[p] = 0;
        end
        for (int cyc = 0; cyc < 2030; cyc++) begin
            @(negedge clk);
            checks++;
            if ($countones({mem_we, mem_re, mem_refresh}) > 1) begin
                errors++;
                $display("FAIL excl_c%0d: we,re,refresh %b expected at most one set", cyc,
                         {mem_we, mem_re, mem_refresh});
            end
            ak[0] = (ack_a === 1'b1);
            ak[1] = (ack_b === 1'b1);
            checks++;
            if (ak[0] && ak[1]) begin
                errors++;
                $display("FAIL dual_ack_c%0d: both acks 1 expected at most one", cyc);
            end
            for (int p = 0; p < 2; p++) begin
                if (ak[p]) begin
                    checks++;
                    if (!r[p]) begin
                        errors++;
                        $display("FAIL spurious_ack_p%0d: ack 1 with no request outstanding", p);
                    end else begin
                        fin[p]++;
                        r[p] = 1'b0;
                        if (w[p]) begin
                            shadow[a[p]] = d[p];
                            sh_vld[a[p]] = 1'b1;
                        end else if (sh_vld[a[p]]) begin
                            checks++;
                            if (rdata !== shadow[a[p]]) begin
                                errors++;
                                $display("FAIL rand_rdata_p%0d: addr %h got %h expected %h", p, a[p], rdata, shadow[a[p]]);
                            end
                        end
                    end
                end
                if (!r[p] && cyc < 2000 && $urandom_range(0, 2) == 0) begin
                    r[p] = 1'b1;
                    w[p] = 1'($urandom_range(0, 1));
                    a[p] = AW'($urandom_range(0, 2**AW - 1));
                    d[p] = DW'($urandom);
                    iss[p]++;
                end
            end
            req_a = r[0]; we_a = w[0]; addr_a = a[0]; wdata_a = d[0];
            req_b = r[1]; we_b = w[1]; addr_b = a[1]; wdata_b = d[1];
        end
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (fin[p] !== iss[p]) begin
                errors++;
                $display("FAIL ack_count_p%0d: acks %0d expected %0d", p, fin[p], iss[p]);
            end
        end
        checks++;
        if (ref_overrun !== 1'b0) begin
            errors++;
            $display("FAIL rand_overrun: got %b expected 0", ref_overrun);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_fairness();
        test_refresh();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end
endmodule
